cu_fsm_mc: RTL and testbench
============================

CU_FSM_MC -- requirements
Module: cu_fsm_mc

Interface
REQ-001 SHALL have parameter N_IRQ, default 4: number of interrupt lines (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum data-memory wait cycles (1..255).
REQ-003 SHALL have parameter IMEM_HS, default 1: 1 = fetch waits on imem_ready; 0 = fetch completes in one cycle.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port INTR  in  N_IRQ  level interrupt requests.
REQ-007 SHALL have port irq_mask  in  N_IRQ  per-line enable, 1 = enabled.
REQ-008 SHALL have port mie  in  1  global interrupt enable.
REQ-009 SHALL have ports opcode  in  7, funct3  in  3, and imm12  in  12 (instruction fields).
REQ-010 SHALL have ports imem_ready  in  1 and dmem_ready  in  1 (memory completion).
REQ-011 SHALL have outputs PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec, bus_err, and illegal  out  1 each (strobes).
REQ-012 SHALL have port irq_id  out  max(1,$clog2(N_IRQ))  id of the taken interrupt.

Function
REQ-013 SHALL use states ST_INIT, ST_FETCH, ST_EXEC, ST_MEM, ST_INTR.
REQ-014 ST_INIT SHALL assert reset for exactly one cycle, then go to ST_FETCH.
REQ-015 ST_FETCH SHALL hold memRDEN1=1; on imem_ready=1 (or unconditionally if IMEM_HS=0), it SHALL pulse PCWrite=1 that cycle and go to ST_EXEC.
REQ-016 ST_EXEC SHALL decode opcode as follows: R-type, OP-IMM, LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111) -> regWrite=1; BRANCH (1100011) -> no strobe.
REQ-017 ST_EXEC LOAD (0000011) SHALL assert memRDEN2=1 and go to ST_MEM; STORE (0100011) SHALL assert memWE2=1 and go to ST_MEM.
REQ-018 ST_EXEC SYSTEM (1110011) with funct3!=0 SHALL assert csr_WE=1 and regWrite=1; funct3=0 with imm12=0x302 SHALL pulse mret_exec=1.
REQ-019 Any other opcode, or SYSTEM with funct3=0 and imm12!=0x302, SHALL pulse illegal=1 and go to ST_INTR with no other strobe.
REQ-020 ST_MEM SHALL hold the memRDEN2 or memWE2 strobe of the current instruction until dmem_ready=1.
REQ-021 ST_MEM on dmem_ready: a LOAD SHALL assert regWrite=1 that cycle; the wait counter SHALL clear.
REQ-022 The wait counter SHALL count ST_MEM cycles with dmem_ready=0; when it reaches TIMEOUT, the FSM SHALL pulse bus_err=1, drop the memory strobe, and go to ST_INTR.
REQ-023 Instruction completion SHALL be an ST_EXEC exit (non-memory, non-illegal) or an ST_MEM exit on dmem_ready.
REQ-024 At completion, pending = INTR & irq_mask; if mie=1 and pending!=0, the next state SHALL be ST_INTR, else ST_FETCH.
REQ-025 Interrupts SHALL be sampled only at completion, never mid-instruction.
REQ-026 The interrupt id SHALL be the lowest set index of pending, latched into irq_id on entry to ST_INTR.
REQ-027 irq_id SHALL hold its value until the next interrupt entry.
REQ-028 ST_INTR SHALL assert int_taken=1 and PCWrite=1 for one cycle, then go to ST_FETCH.
REQ-029 For illegal or bus_err entry to ST_INTR, irq_id SHALL be unchanged.
REQ-030 A completion that coincides with mret_exec SHALL not take an interrupt in the same instruction.
REQ-031 All strobes SHALL be combinational from state and inputs; default value is 0; at most one of memRDEN2 or memWE2 SHALL be high at a time.

Reset
REQ-032 RST_N=0 at a rising edge SHALL force ST_INIT, clear the wait counter, and set irq_id to 0, in any state including mid-ST_MEM.
REQ-033 While in reset, all strobes except reset SHALL be 0.

Structure
REQ-034 A shared package cu_pkg SHALL hold the opcode localparams, the MRET_IMM constant 0x302, and the state enum.
REQ-035 Sub-module prio_enc (parametrised N_IRQ, lowest-index-wins, valid output) SHALL compute the interrupt id.

Verification
REQ-036 Reset then ADDI opcode with imem_ready=1: reset pulses 1 cycle; FETCH with PCWrite=1; EXEC with regWrite=1; back to FETCH.
REQ-037 LW with dmem_ready low 3 cycles: memRDEN2 high for 4 ST_MEM cycles; regWrite=1 only on the ready cycle.
REQ-038 SW with dmem_ready stuck 0 and TIMEOUT=15: bus_err pulses after 15 ST_MEM cycles; int_taken follows next cycle.
REQ-039 INTR=4'b1010, irq_mask=4'b1110, mie=1 at ADD completion: ST_INTR entered; int_taken=1; irq_id=1; then FETCH.
REQ-040 Opcode 0000000: illegal=1, no regWrite; ST_INTR next.
REQ-041 RST_N=0 asserted mid-ST_MEM: next state ST_INIT; memRDEN2=0 during reset; irq_id=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, the MRET
// immediate, the FSM state encoding and the interrupt-id width helper.
package cu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [11:0] MRET_IMM = 12'h302;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_INTR
  } state_e;

  // A single interrupt line still needs a 1-bit id port.
  function automatic int irq_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder used to pick the interrupt to service.
module prio_enc
  import cu_pkg::*;
#(
  parameter int N_IRQ = 4,
  localparam int W    = irq_id_w(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic [W-1:0]     id_o,
  output logic             valid_o
);

  // Scan high to low so the last hit, the lowest index, is what remains.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_fsm_mc.sv
// Multi-cycle control unit FSM: fetch / execute / memory wait with timeout,
// plus precise interrupt entry sampled only at instruction completion.
module cu_fsm_mc
  import cu_pkg::*;
#(
  parameter int N_IRQ   = 4,
  parameter int TIMEOUT = 15,
  parameter int IMEM_HS = 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [N_IRQ-1:0]             INTR,
  input  logic [N_IRQ-1:0]             irq_mask,
  input  logic                         mie,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [11:0]                  imm12,
  input  logic                         imem_ready,
  input  logic                         dmem_ready,
  output logic                         PCWrite,
  output logic                         regWrite,
  output logic                         memWE2,
  output logic                         memRDEN1,
  output logic                         memRDEN2,
  output logic                         reset,
  output logic                         csr_WE,
  output logic                         int_taken,
  output logic                         mret_exec,
  output logic                         bus_err,
  output logic                         illegal,
  output logic [irq_id_w(N_IRQ)-1:0]   irq_id
);

  localparam int         IDW = irq_id_w(N_IRQ);
  localparam logic [7:0] TO  = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;
  logic             is_load_q, is_load_d;

  logic [IDW-1:0]   pend_id;
  logic             pend_valid;
  logic             complete;

  prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req_i   (INTR & irq_mask),
    .id_o    (pend_id),
    .valid_o (pend_valid)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= '0;
      irq_id_q   <= '0;
      is_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      irq_id_q   <= irq_id_d;
      is_load_q  <= is_load_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    irq_id_d   = irq_id_q;
    is_load_d  = is_load_q;
    complete   = 1'b0;
    PCWrite    = 1'b0;
    regWrite   = 1'b0;
    memWE2     = 1'b0;
    memRDEN1   = 1'b0;
    memRDEN2   = 1'b0;
    reset      = 1'b0;
    csr_WE     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    bus_err    = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_INIT: begin
        reset   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        memRDEN1 = 1'b1;
        if (IMEM_HS == 0 || imem_ready) begin
          PCWrite = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            regWrite = 1'b1;
            complete = 1'b1;
          end
          OP_BRANCH: complete = 1'b1;
          OP_LOAD: begin
            memRDEN2  = 1'b1;
            is_load_d = 1'b1;
            state_d   = ST_MEM;
          end
          OP_STORE: begin
            memWE2    = 1'b1;
            is_load_d = 1'b0;
            state_d   = ST_MEM;
          end
          OP_SYSTEM: begin
            if (funct3 != 3'd0) begin
              csr_WE   = 1'b1;
              regWrite = 1'b1;
              complete = 1'b1;
            end else if (imm12 == MRET_IMM) begin
              mret_exec = 1'b1;
              complete  = 1'b1;
            end else begin
              illegal = 1'b1;
              state_d = ST_INTR;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = ST_INTR;
          end
        endcase
      end
      ST_MEM: begin
        // The timeout cycle itself carries no memory strobe.
        if (wait_cnt_q == TO) begin
          bus_err    = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_INTR;
        end else begin
          memRDEN2 = is_load_q;
          memWE2   = !is_load_q;
          if (dmem_ready) begin
            regWrite   = is_load_q;
            wait_cnt_d = '0;
            complete   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ST_INTR: begin
        int_taken = 1'b1;
        PCWrite   = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase

    if (complete) begin
      if (mie && pend_valid && !mret_exec) begin
        state_d  = ST_INTR;
        irq_id_d = pend_id;
      end else begin
        state_d = ST_FETCH;
      end
    end

    // Reset dominates: only the reset strobe may show while RST_N is low.
    if (!RST_N) begin
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      bus_err   = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Directed bench for cu_fsm_mc: expected strobe vectors are queued as each
// cycle's stimulus is applied and popped/compared mid-cycle.
module tb_cu_fsm_mc;
  import cu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  INTR, irq_mask;
  logic        mie;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm12;
  logic        imem_ready, dmem_ready;
  logic        PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset;
  logic        csr_WE, int_taken, mret_exec, bus_err, illegal;
  logic [1:0]  irq_id;

  always #5 CLK = ~CLK;

  cu_fsm_mc #(.N_IRQ(4), .TIMEOUT(15), .IMEM_HS(1)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .INTR       (INTR),
    .irq_mask   (irq_mask),
    .mie        (mie),
    .opcode     (opcode),
    .funct3     (funct3),
    .imm12      (imm12),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .PCWrite    (PCWrite),
    .regWrite   (regWrite),
    .memWE2     (memWE2),
    .memRDEN1   (memRDEN1),
    .memRDEN2   (memRDEN2),
    .reset      (reset),
    .csr_WE     (csr_WE),
    .int_taken  (int_taken),
    .mret_exec  (mret_exec),
    .bus_err    (bus_err),
    .illegal    (illegal),
    .irq_id     (irq_id)
  );

  // Strobe vector bit positions.
  localparam logic [10:0] S_NONE = 11'd0;
  localparam logic [10:0] S_PCW  = 11'b100_0000_0000;
  localparam logic [10:0] S_RW   = 11'b010_0000_0000;
  localparam logic [10:0] S_WE2  = 11'b001_0000_0000;
  localparam logic [10:0] S_RD1  = 11'b000_1000_0000;
  localparam logic [10:0] S_RD2  = 11'b000_0100_0000;
  localparam logic [10:0] S_RST  = 11'b000_0010_0000;
  localparam logic [10:0] S_CSR  = 11'b000_0001_0000;
  localparam logic [10:0] S_INT  = 11'b000_0000_1000;
  localparam logic [10:0] S_MRET = 11'b000_0000_0100;
  localparam logic [10:0] S_BERR = 11'b000_0000_0010;
  localparam logic [10:0] S_ILL  = 11'b000_0000_0001;

  logic [10:0] strobes;
  assign strobes = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
                    csr_WE, int_taken, mret_exec, bus_err, illegal};

  logic [10:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cyc(input string tag, input logic [10:0] exp);
    logic [10:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge CLK);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (strobes === e) else begin
      bad++;
      $error("FAIL %s strobes got=%b exp=%b", t, strobes, e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [1:0] exp);
    total++;
    assert (irq_id === exp) else begin
      bad++;
      $error("FAIL %s irq_id got=%0d exp=%0d", tag, irq_id, exp);
    end
  endtask

  task automatic fetch(input string tag);
    imem_ready = 1'b1;
    cyc(tag, S_RD1 | S_PCW);
    imem_ready = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [11:0] imm, input logic [10:0] exp);
    opcode = op;
    funct3 = f3;
    imm12  = imm;
    cyc(tag, exp);
  endtask

  task automatic irqs(input logic [3:0] lines, input logic [3:0] mask, input logic en);
    INTR     = lines;
    irq_mask = mask;
    mie      = en;
  endtask

  initial begin
    RST_N      = 1'b0;
    irqs(4'b0000, 4'b0000, 1'b0);
    opcode     = 7'd0;
    funct3     = 3'd0;
    imm12      = 12'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge CLK);
    #1;

    // Reset, then ADDI through fetch/exec and back to fetch.
    cyc("rst_hold", S_RST);
    chk_id("rst_id", 2'd0);
    RST_N = 1'b1;
    cyc("rst_pulse", S_RST);
    cyc("fetch_wait", S_RD1);
    fetch("fetch_addi");
    exec("exec_addi", OP_IMM, 3'd0, 12'd0, S_RW);
    fetch("fetch_after_addi");

    // Remaining non-memory decodes.
    exec("exec_branch", OP_BRANCH, 3'd0, 12'd0, S_NONE);
    fetch("fetch_after_branch");
    exec("exec_csr", OP_SYSTEM, 3'd1, 12'h300, S_CSR | S_RW);
    fetch("fetch_after_csr");

    // LW with three not-ready cycles.
    exec("exec_lw", OP_LOAD, 3'd2, 12'd0, S_RD2);
    for (int i = 0; i < 3; i++) cyc("lw_wait", S_RD2);
    dmem_ready = 1'b1;
    cyc("lw_ready", S_RD2 | S_RW);
    dmem_ready = 1'b0;
    fetch("fetch_after_lw");

    // Pending but masked, and pending with mie=0: no interrupt.
    irqs(4'b0001, 4'b1110, 1'b1);
    exec("exec_add_masked", OP_RTYPE, 3'd0, 12'd0, S_RW);
    fetch("fetch_after_masked");
    irqs(4'b0010, 4'b1111, 1'b0);
    exec("exec_jal_mie0", OP_JAL, 3'd0, 12'd0, S_RW);
    fetch("fetch_after_mie0");

    // ADD completion with INTR=1010, mask=1110: lowest pending is line 1.
    irqs(4'b1010, 4'b1110, 1'b1);
    exec("exec_add_irq", OP_RTYPE, 3'd0, 12'd0, S_RW);
    chk_id("irq_id_add", 2'd1);
    irqs(4'b0000, 4'b1110, 1'b1);
    cyc("intr_add", S_INT | S_PCW);
    chk_id("irq_id_hold", 2'd1);
    fetch("fetch_after_intr");

    // MRET completion with a pending interrupt must not take it.
    irqs(4'b1000, 4'b1111, 1'b1);
    exec("exec_mret", OP_SYSTEM, 3'd0, MRET_IMM, S_MRET);
    irqs(4'b0000, 4'b1111, 1'b1);
    fetch("fetch_after_mret");

    // Interrupt raised while the LOAD finishes in ST_MEM.
    exec("exec_lw_irq", OP_LOAD, 3'd2, 12'd0, S_RD2);
    cyc("lw_irq_wait", S_RD2);
    dmem_ready = 1'b1;
    irqs(4'b1000, 4'b1111, 1'b1);
    cyc("lw_irq_ready", S_RD2 | S_RW);
    dmem_ready = 1'b0;
    irqs(4'b0000, 4'b1111, 1'b1);
    chk_id("irq_id_lw", 2'd3);
    cyc("intr_lw", S_INT | S_PCW);
    fetch("fetch_after_lw_irq");

    // SW timeout: 15 waiting cycles, then bus_err, then int_taken.
    exec("exec_sw", OP_STORE, 3'd2, 12'd0, S_WE2);
    for (int i = 0; i < 15; i++) cyc("sw_wait", S_WE2);
    cyc("sw_bus_err", S_BERR);
    cyc("intr_bus_err", S_INT | S_PCW);
    chk_id("irq_id_bus_err", 2'd3);
    fetch("fetch_after_bus_err");

    // Illegal opcode and ECALL-like SYSTEM both trap without irq_id change.
    exec("exec_illegal", 7'b0000000, 3'd0, 12'd0, S_ILL);
    cyc("intr_illegal", S_INT | S_PCW);
    chk_id("irq_id_illegal", 2'd3);
    fetch("fetch_after_illegal");
    exec("exec_ecall", OP_SYSTEM, 3'd0, 12'h000, S_ILL);
    cyc("intr_ecall", S_INT | S_PCW);
    fetch("fetch_after_ecall");

    // Reset asserted mid-ST_MEM.
    exec("exec_lw_rst", OP_LOAD, 3'd2, 12'd0, S_RD2);
    cyc("lw_rst_wait", S_RD2);
    RST_N = 1'b0;
    cyc("rst_in_mem", S_NONE);
    chk_id("irq_id_rst", 2'd0);
    cyc("rst_init_hold", S_RST);
    RST_N = 1'b1;
    cyc("rst_init_pulse", S_RST);
    fetch("fetch_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
